// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Register fields are held at a fixed width; narrower REG_AW values are zero-extended.
  localparam int unsigned SHADOW_AW = 8;

  // Destination/source metadata of one in-flight instruction
  typedef struct packed {
    logic                 valid;
    logic [SHADOW_AW-1:0] rd;
    logic [SHADOW_AW-1:0] rs1;
    logic [SHADOW_AW-1:0] rs2;
    logic                 reg_write;
    logic                 mem_read;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  // Pick the youngest producer of src; x0 is never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic [SHADOW_AW-1:0] src,
    input logic                 mem_valid,
    input logic                 mem_reg_write,
    input logic [SHADOW_AW-1:0] mem_rd,
    input logic                 wb_valid,
    input logic                 wb_reg_write,
    input logic [SHADOW_AW-1:0] wb_rd
  );
    if (mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == src)) return FWD_MEM;
    if (wb_valid && wb_reg_write && (wb_rd != '0) && (wb_rd == src)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear wins over increment; hold at all-ones once reached
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection, operand forwarding and stall/flush accounting for the 5-stage pipe.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter bit          BR_IN_MEM = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              redirect,
  input  logic              mem_busy,
  input  logic              clr_cnt,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_t id_s;
  stage_t ex_q;
  stage_t mem_q;
  stage_t wb_q;

  logic load_use;
  logic redirect_acc;
  logic load_use_acc;

  // Fields not needed by any hazard check in later stages
  logic unused_fields;
  assign unused_fields = ^{ex_q.reg_write, mem_q.rs1, mem_q.rs2, mem_q.mem_read,
                           wb_q.rs1, wb_q.rs2, wb_q.mem_read};

  // ID-stage metadata widened to shadow width
  always_comb begin
    id_s           = BUBBLE;
    id_s.valid     = id_valid;
    id_s.rd        = SHADOW_AW'(id_rd);
    id_s.rs1       = SHADOW_AW'(id_rs1);
    id_s.rs2       = SHADOW_AW'(id_rs2);
    id_s.reg_write = id_reg_write;
    id_s.mem_read  = id_mem_read;
  end

  // Hazard detection and pipeline register control
  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
               ((id_uses_rs1 && (id_s.rs1 == ex_q.rd)) ||
                (id_uses_rs2 && (id_s.rs2 == ex_q.rd)));
    // A frozen pipe accepts nothing; a redirect squashes the dependent load-use victim anyway
    redirect_acc = redirect && !mem_busy;
    load_use_acc = load_use && !redirect && !mem_busy;

    pc_en       = !mem_busy && !load_use_acc;
    ifid_en     = !mem_busy && !load_use_acc;
    ifid_flush  = redirect_acc;
    idex_flush  = redirect_acc || load_use_acc;
    exmem_flush = redirect_acc && BR_IN_MEM;
  end

  // Operand forwarding from the EX shadow's sources
  always_comb begin
    fwd_a = fwd_select(ex_q.rs1, mem_q.valid, mem_q.reg_write, mem_q.rd,
                       wb_q.valid, wb_q.reg_write, wb_q.rd);
    fwd_b = fwd_select(ex_q.rs2, mem_q.valid, mem_q.reg_write, mem_q.rd,
                       wb_q.valid, wb_q.reg_write, wb_q.rd);
  end

  // Shadow stage registers advance with the pipe, hold while memory is busy
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (!mem_busy) begin
      wb_q  <= mem_q;
      mem_q <= exmem_flush ? BUBBLE : ex_q;
      ex_q  <= idex_flush ? BUBBLE : id_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (mem_busy || load_use_acc),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (redirect_acc),
    .q   (flush_cnt)
  );

endmodule
